// File: rtl/xmul_carry_norm.sv
// rtl/xmul_carry_norm.sv - carry-normalisation stage for reduced-radix column accumulators
// Splits each 64-bit column into a canonical limb plus a running carry, and closes each packet with a carry limb.
module xmul_carry_norm #(
    parameter int LIMB_W = 57,
    parameter int NLIMBS = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_first,
    input  logic        in_last,
    input  logic [4:0]  in_tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic [4:0]  out_tag,
    output logic        busy,
    output logic        err
);

    localparam int CARRY_W = 65 - LIMB_W;
    localparam int CNT_W   = $clog2(NLIMBS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CARRY = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CARRY_W-1:0] carry_q, carry_d;
    logic [4:0]         tag_q, tag_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic [63:0]        out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [4:0]         out_tag_q, out_tag_d;
    logic               err_q, err_d;

    logic               accept;
    logic               reg_free;
    logic               eff_first;
    logic [CARRY_W-1:0] add_carry;
    logic [64:0]        sum;

    // The output register may be refilled whenever it is empty or being drained this cycle.
    assign reg_free  = !out_valid_q || out_ready;
    assign in_ready  = (state_q != ST_CARRY) && reg_free;
    assign accept    = in_valid && in_ready;

    // A stray beat while idle is treated as a packet start so the stream can resynchronise.
    assign eff_first = in_first || (state_q == ST_IDLE);
    assign add_carry = eff_first ? '0 : carry_q;
    assign sum       = {1'b0, in_data} + {{(65 - CARRY_W){1'b0}}, add_carry};

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        tag_d       = tag_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_tag_d   = out_tag_q;
        err_d       = err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = {{(64 - LIMB_W){1'b0}}, sum[LIMB_W-1:0]};
            out_last_d  = 1'b0;
            out_tag_d   = eff_first ? in_tag : tag_q;
            carry_d     = sum[64:LIMB_W];
            state_d     = in_last ? ST_CARRY : ST_RUN;

            if (eff_first) begin
                tag_d   = in_tag;
                count_d = {{(CNT_W - 1){1'b0}}, 1'b1};
            end else if (count_q != '1) begin
                count_d = count_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            end

            if ((state_q == ST_IDLE) && !in_first) begin
                err_d = 1'b1;
            end
            if ((state_q == ST_RUN) && in_first) begin
                err_d = 1'b1;
            end
            if (!eff_first && !in_last && (count_q == CNT_W'(NLIMBS))) begin
                err_d = 1'b1;
            end
        end else if ((state_q == ST_CARRY) && reg_free) begin
            out_valid_d = 1'b1;
            out_data_d  = {{(64 - CARRY_W){1'b0}}, carry_q};
            out_last_d  = 1'b1;
            out_tag_d   = tag_q;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            carry_q     <= '0;
            tag_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_tag_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            tag_q       <= tag_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_tag_q   <= out_tag_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_tag   = out_tag_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_xmul_carry_norm.sv
// tb/tb_xmul_carry_norm.sv - scoreboard bench for xmul_carry_norm
// Driver pushes hand-computed limbs; a negedge monitor pops and compares on each output transfer.
module tb_xmul_carry_norm;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_last;
    logic [4:0]  out_tag;
    logic        busy;
    logic        err;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    logic bp_mode = 1'b0;

    xmul_carry_norm #(.LIMB_W(57), .NLIMBS(9)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_tag   (out_tag),
        .busy      (busy),
        .err       (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_limb(input logic [63:0] d, input logic l, input logic [4:0] t);
        exp_t e;
        e.data = d;
        e.last = l;
        e.tag  = t;
        sb.push_back(e);
    endtask

    // Back-pressure pattern: toggle out_ready every cycle.
    always @(posedge clock) begin
        #1;
        if (bp_mode) out_ready = ~out_ready;
    end

    logic        stall_prev = 1'b0;
    logic [63:0] held_data;
    logic        held_last;
    logic [4:0]  held_tag;

    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) begin
                chk("stall_data", out_data, held_data);
                chk("stall_last", {63'd0, out_last}, {63'd0, held_last});
                chk("stall_tag", {59'd0, out_tag}, {59'd0, held_tag});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", out_data, 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", {63'd0, out_last}, {63'd0, e.last});
                    chk("out_tag", {59'd0, out_tag}, {59'd0, e.tag});
                end
            end
            if (out_valid && !out_ready) begin
                chk("in_ready_stall", {63'd0, in_ready}, 64'd0);
                held_data  = out_data;
                held_last  = out_last;
                held_tag   = out_tag;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic f, input logic l, input logic [4:0] t);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        in_last  = l;
        in_tag   = t;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (!in_ready) begin
            chk("send_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            in_first = 1'b0;
            in_last  = 1'b0;
            chk("accept_latency", {63'd0, out_valid}, 64'd1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clock);
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (sb.size() != 0 || out_valid) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic basic_packet();
        expect_limb(64'd5, 1'b0, 5'd3);
        expect_limb(64'd0, 1'b0, 5'd3);
        expect_limb(64'd1, 1'b1, 5'd3);
        send(64'h0200_0000_0000_0005, 1'b1, 1'b0, 5'd3);
        send(64'h01FF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 5'd3);
        drain();
    endtask

    initial begin
        do_reset();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        basic_packet();
        chk("basic_err", {63'd0, err}, 64'd0);

        expect_limb(64'h01FF_FFFF_FFFF_FFFF, 1'b0, 5'd7);
        expect_limb(64'd126, 1'b0, 5'd7);
        for (int i = 0; i < 7; i++) expect_limb(64'd127, 1'b0, 5'd7);
        expect_limb(64'd128, 1'b1, 5'd7);
        for (int i = 0; i < 9; i++) send(64'hFFFF_FFFF_FFFF_FFFF, i == 0, i == 8, 5'd7);
        drain();
        chk("sat_err", {63'd0, err}, 64'd0);

        bp_mode = 1'b1;
        basic_packet();
        bp_mode = 1'b0;
        out_ready = 1'b1;

        expect_limb(64'd7, 1'b0, 5'd12);
        expect_limb(64'd2, 1'b1, 5'd12);
        send(64'h0400_0000_0000_0007, 1'b1, 1'b1, 5'd12);
        drain();
        chk("single_idle_busy", {63'd0, busy}, 64'd0);
        chk("single_idle_ready", {63'd0, in_ready}, 64'd1);
        chk("single_err", {63'd0, err}, 64'd0);

        // in_first mid-packet restarts carry and tag.
        expect_limb(64'd5, 1'b0, 5'd4);
        expect_limb(64'd3, 1'b0, 5'd6);
        expect_limb(64'd1, 1'b0, 5'd6);
        expect_limb(64'd1, 1'b1, 5'd6);
        send(64'h0200_0000_0000_0005, 1'b1, 1'b0, 5'd4);
        chk("restart_err_before", {63'd0, err}, 64'd0);
        send(64'h0400_0000_0000_0003, 1'b1, 1'b0, 5'd6);
        chk("restart_err", {63'd0, err}, 64'd1);
        send(64'h01FF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 5'd6);
        drain();
        chk("restart_err_sticky", {63'd0, err}, 64'd1);

        do_reset();
        chk("reset_clears_err", {63'd0, err}, 64'd0);

        for (int i = 1; i <= 11; i++) expect_limb(64'(i), 1'b0, 5'd9);
        expect_limb(64'd0, 1'b1, 5'd9);
        for (int i = 1; i <= 11; i++) begin
            send(64'(i), i == 1, i == 11, 5'd9);
            if (i == 9) chk("count_err_9", {63'd0, err}, 64'd0);
            if (i == 10) chk("count_err_10", {63'd0, err}, 64'd1);
        end
        drain();
        chk("count_err_sticky", {63'd0, err}, 64'd1);

        // Reset while a limb is stalled in the output register.
        do_reset();
        out_ready = 1'b0;
        send(64'h0200_0000_0000_0005, 1'b1, 1'b0, 5'd3);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        out_ready = 1'b1;
        basic_packet();
        chk("midrst_err", {63'd0, err}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/xmul_carry_norm.md
# xmul_carry_norm

Carry-normalisation stage directly downstream of the CSIDH-512 reduced-radix multiply-accumulate unit. It consumes the stream of 64-bit column accumulators produced by the `madd57lu`/`madd57hu` sequences. It propagates carries limb by limb, emits canonical 57-bit limbs plus one final carry limb, and tags each output with the packet tag. It buffers one output limb and supports back-pressure via a valid/ready handshake on both sides.

## Interface
- `LIMB_W`, 57: output limb width in bits; the carry register is `65-LIMB_W` bits wide.
- `NLIMBS`, 9: maximum input limbs per packet before `err` is raised.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: stage accepts a beat this cycle.
- `in_data` in 64: column accumulator (unsigned).
- `in_first` in 1: first limb of packet; clears carry before the add.
- `in_last` in 1: last limb of packet.
- `in_tag` in 5: packet tag, sampled on `in_first` beats.
- `out_valid` out 1: output limb valid.
- `out_ready` in 1: consumer accepts the output limb.
- `out_data` out 64: `{7'd0, limb[56:0]}`.
- `out_last` out 1: marks the final (carry) limb of a packet.
- `out_tag` out 5: tag of the packet being emitted.
- `busy` out 1: high in RUN or CARRY, or while `out_valid` is high.
- `err` out 1: sticky protocol error; cleared only by `reset`.

## Operation
- Handshake:
  - Input accepted when `in_valid && in_ready`.
  - Output transfers when `out_valid && out_ready`.
  - `in_ready = (state != CARRY) && (!out_valid || out_ready)`.
- Arithmetic on accept:
  - `sum[64:0] = in_data + (in_first ? 0 : carry)`.
  - Output register loads `sum[56:0]`, zero-extended.
  - `carry <= sum[64:57]`; max reachable carry is 128, so 8 bits never overflow.
- Tag: `tag_q <= in_tag` on `in_first` beats. Every output carries `tag_q`, or `in_tag` for the `in_first` beat itself.
- FSM states:
  - IDLE: accepted beat with `in_first` goes to RUN. If that beat also has `in_last`, go to CARRY instead. A beat without `in_first` sets `err` and is processed as if `in_first` were high.
  - RUN: accepted beat with `in_last` goes to CARRY. Accepted beat with `in_first` sets `err`, restarts the packet (carry cleared, tag resampled, count reset) and stays in RUN.
  - CARRY: `in_ready=0`. When the output register is empty or draining this cycle, it loads `{56'd0, carry}` with `out_last=1`, then goes to IDLE.
- Limb counter:
  - Reset to 1 on `in_first` accept; increments on every other accept.
  - Accepting a non-last beat when the count is already `NLIMBS` sets `err`; processing continues unchanged.
- Output register holds data/tag/last stable while `out_valid && !out_ready`.
- Output limbs per packet = input limbs + 1.

## Timing
- Reset values:
  - `out_valid`, `out_data`, `out_last`, `out_tag`, `busy`, `err` = 0.
  - `in_ready` = 1 in the first cycle after reset.
  - state = IDLE, carry = 0, count = 0.
- Latency: input accept in cycle N gives `out_valid` in cycle N+1. Carry limb appears the cycle after the last data limb leaves the register. With `out_ready` held high it appears at N+2 after the `in_last` accept.
- Throughput: 1 limb/cycle inside a packet with `out_ready` high. One bubble on the input side per packet, for the CARRY state.
- Simultaneous output drain and input accept in the same cycle is legal; the register reloads with no bubble.
- `reset` mid-packet: all state cleared next edge, and the in-flight output limb is dropped.

## Test plan
- Basic carry: beats `0x0200000000000005` (first), `0x01FFFFFFFFFFFFFF` (last), tag 3, `out_ready=1` -> outputs `5`, `0`, `1` (`out_last`), all `out_tag=3`, `err=0`.
- Saturation: 9 beats of `0xFFFFFFFFFFFFFFFF` -> limbs `0x1FFFFFFFFFFFFFF`, `126`, then `127` ×7, carry limb `128`; no overflow.
- Back-pressure: same as the basic-carry stimulus, `out_ready` toggling 0/1 each cycle -> identical data sequence; `out_data` stable while stalled; `in_ready=0` whenever `out_valid && !out_ready`.
- Single-limb packet: one beat `0x0400000000000007` with `in_first` and `in_last` -> outputs `7`, then `2` (`out_last`); state back to IDLE.
- Protocol errors:
  - `in_first` during RUN -> `err=1`, carry restarted.
  - 10 non-last beats -> `err=1` on the 10th.
  - `err` stays 1 until `reset`.
- Reset mid-packet: assert `reset` while `out_valid=1` and `out_ready=0` -> next cycle `out_valid=0`, `in_ready=1`, `busy=0`. A new packet then behaves as in the basic-carry case.
